// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: turns one deserialised 10-bit TMDS word per pixel
// clock back into DE, C0/C1 and an 8-bit pixel. It also runs the word
// alignment loop: search for a run of control tokens, ask the deserialiser
// for a bitslip when none shows up, and watch the lock once it is found.
module tmds_channel_decoder #(
    parameter int TOKEN_RUN     = 16,
    parameter int SEARCH_LIMIT  = 4096,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_tmds,
    output logic       o_bitslip,
    output logic       o_aligned,
    output logic       o_de,
    output logic       o_c0,
    output logic       o_c1,
    output logic [7:0] o_data
);

    // Shared cycle counter covers both the search/watchdog window and the
    // settle wait, so SETTLE_CYCLES must not exceed SEARCH_LIMIT.
    localparam int CW = (SEARCH_LIMIT > 1) ? $clog2(SEARCH_LIMIT) : 1;
    // The run counter has to hold TOKEN_RUN itself, since it saturates there.
    localparam int RW = $clog2(TOKEN_RUN + 1);

    localparam logic [CW-1:0] CYC_MAX    = CW'(SEARCH_LIMIT - 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RUN_MAX    = RW'(TOKEN_RUN);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One decoded pixel-clock output word.
    typedef struct packed {
        logic       de;
        logic       c1;
        logic       c0;
        logic [7:0] data;
    } pix_t;

    state_t        state_q, state_nxt;
    logic [CW-1:0] cyc_q, cyc_nxt;
    logic [RW-1:0] run_q, run_nxt, run_adv;
    logic          run_hit;
    logic          bitslip_q, bitslip_nxt;
    logic          is_tok;
    logic [1:0]    tok_c;
    logic [7:0]    d_unmask;
    logic [7:0]    dec_byte;
    pix_t          pix_q, pix_nxt;

    // Recognise the four control tokens and recover C1:C0 from them.
    always_comb begin
        is_tok = 1'b1;
        tok_c  = 2'b00;
        case (i_tmds)
            10'h354: tok_c = 2'b00;
            10'h0AB: tok_c = 2'b01;
            10'h154: tok_c = 2'b10;
            10'h2AB: tok_c = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    // Undo the transition-minimising encode. Bit 9 flags an inverted
    // payload. Bit 8 picks XOR (1) or XNOR (0) between neighbouring bits;
    // XNOR is XOR plus an inversion of bits 7..1, bit 0 is passed through.
    always_comb begin
        d_unmask = i_tmds[9] ? ~i_tmds[7:0] : i_tmds[7:0];
        dec_byte = d_unmask ^ {d_unmask[6:0], 1'b0} ^ {{7{~i_tmds[8]}}, 1'b0};
    end

    // Token run length for this word: saturating count, cleared by data.
    // A hit is the single edge on which the run first reaches TOKEN_RUN.
    always_comb begin
        if (!is_tok)
            run_adv = '0;
        else if (run_q == RUN_MAX)
            run_adv = RUN_MAX;
        else
            run_adv = run_q + RW'(1);
        run_hit = (run_adv == RUN_MAX) && (run_q != RUN_MAX);
    end

    // Alignment FSM: next state, counters and the bitslip request.
    always_comb begin
        state_nxt   = state_q;
        cyc_nxt     = cyc_q;
        run_nxt     = run_q;
        bitslip_nxt = 1'b0;
        case (state_q)
            SEARCH: begin
                run_nxt = run_adv;
                if (run_hit) begin
                    // A hit on the final search cycle still wins over bitslip.
                    state_nxt = LOCKED;
                    cyc_nxt   = '0;
                end else if (cyc_q == CYC_MAX) begin
                    bitslip_nxt = 1'b1;
                    state_nxt   = SETTLE;
                    cyc_nxt     = '0;
                    run_nxt     = '0;
                end else begin
                    cyc_nxt = cyc_q + CW'(1);
                end
            end
            SETTLE: begin
                // Words are meaningless while the deserialiser shifts phase.
                run_nxt = '0;
                if (cyc_q == SETTLE_MAX) begin
                    state_nxt = SEARCH;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc_q + CW'(1);
                end
            end
            LOCKED: begin
                run_nxt = run_adv;
                if (run_hit) begin
                    cyc_nxt = '0;
                end else if (cyc_q == CYC_MAX) begin
                    // Lock lost: search again from the current phase first.
                    state_nxt = SEARCH;
                    cyc_nxt   = '0;
                    run_nxt   = '0;
                end else begin
                    cyc_nxt = cyc_q + CW'(1);
                end
            end
            default: begin
                state_nxt = SEARCH;
                cyc_nxt   = '0;
                run_nxt   = '0;
            end
        endcase
    end

    // Output word, gated by the state this edge moves into. C1:C0 hold
    // their last token value across data periods; LOCKED is only ever
    // entered on a token, so the held value is always a real one.
    always_comb begin
        pix_nxt = '0;
        if (state_nxt == LOCKED) begin
            if (is_tok) begin
                pix_nxt.c1 = tok_c[1];
                pix_nxt.c0 = tok_c[0];
            end else begin
                pix_nxt.de   = 1'b1;
                pix_nxt.c1   = pix_q.c1;
                pix_nxt.c0   = pix_q.c0;
                pix_nxt.data = dec_byte;
            end
        end
    end

    // State, counters and registered outputs; reset aborts everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            cyc_q     <= '0;
            run_q     <= '0;
            bitslip_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            state_q   <= state_nxt;
            cyc_q     <= cyc_nxt;
            run_q     <= run_nxt;
            bitslip_q <= bitslip_nxt;
            pix_q     <= pix_nxt;
        end
    end

    assign o_bitslip = bitslip_q;
    assign o_aligned = (state_q == LOCKED);
    assign o_de      = pix_q.de;
    assign o_c1      = pix_q.c1;
    assign o_c0      = pix_q.c0;
    assign o_data    = pix_q.data;

    // A bitslip is always followed by SETTLE, so it can never repeat back to back.
    a_bitslip_pulse: assert property (@(posedge clk) disable iff (rst)
        o_bitslip |=> !o_bitslip);

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: a behavioural model of the alignment
// rules is checked every cycle, and directed scenarios pin literal values.
module tb_tmds_channel_decoder;

    localparam int TR = 16;
    localparam int SL = 64;
    localparam int SC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] i_tmds = '0;
    logic       o_bitslip, o_aligned, o_de, o_c0, o_c1;
    logic [7:0] o_data;

    tmds_channel_decoder #(.TOKEN_RUN(TR), .SEARCH_LIMIT(SL), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .i_tmds(i_tmds),
        .o_bitslip(o_bitslip), .o_aligned(o_aligned), .o_de(o_de),
        .o_c0(o_c0), .o_c1(o_c1), .o_data(o_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0 searching, 1 settling, 2 locked.
    int         m_mode = 0;
    int         m_cnt  = 0;
    int         m_run  = 0;
    logic       m_bs = 0, m_de = 0, m_c0 = 0, m_c1 = 0;
    logic [7:0] m_data = 0;
    bit         live = 0;

    function automatic int tok_code(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] w);
        logic [7:0] d, o;
        d = w[9] ? ~w[7:0] : w[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++)
            o[i] = w[8] ? (d[i] ^ d[i-1]) : !(d[i] ^ d[i-1]);
        return o;
    endfunction

    function automatic logic [9:0] rnd_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (tok_code(w) >= 0);
        return w;
    endfunction

    function automatic logic [9:0] rnd_tok();
        logic [9:0] t [4];
        t[0] = 10'h354; t[1] = 10'h0AB; t[2] = 10'h154; t[3] = 10'h2AB;
        return t[$urandom_range(0, 3)];
    endfunction

    // Reference behaviour, evaluated on every rising edge.
    always @(posedge clk) begin
        int  code, prev;
        bit  hit;
        live = 1;
        m_bs = 0;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_run = 0;
            m_de = 0; m_c0 = 0; m_c1 = 0; m_data = 0;
        end else begin
            code = tok_code(i_tmds);
            if (m_mode == 1) begin
                m_run = 0;
                m_cnt = m_cnt + 1;
                if (m_cnt == SC) begin m_mode = 0; m_cnt = 0; end
            end else begin
                prev  = m_run;
                m_run = (code >= 0) ? ((m_run < TR) ? m_run + 1 : TR) : 0;
                hit   = (m_run == TR) && (prev != TR);
                if (hit) begin
                    m_mode = 2; m_cnt = 0;
                end else if (m_cnt == SL - 1) begin
                    if (m_mode == 0) m_bs = 1;
                    m_mode = (m_mode == 0) ? 1 : 0;
                    m_cnt = 0; m_run = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (m_mode != 2) begin
                m_de = 0; m_c0 = 0; m_c1 = 0; m_data = 0;
            end else if (code >= 0) begin
                m_de = 0; m_data = 0;
                m_c1 = code[1]; m_c0 = code[0];
            end else begin
                m_de = 1; m_data = decode(i_tmds);
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        logic [12:0] act, exp;
        if (live) begin
            act = {o_bitslip, o_aligned, o_de, o_c1, o_c0, o_data};
            exp = {m_bs, (m_mode == 2), m_de, m_c1, m_c0, m_data};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model t=%0t got bs/al/de/c1/c0/data=%b expected %b", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic [9:0] w, input logic r);
        i_tmds = w;
        rst    = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic reset1();
        tick(rnd_data(), 1'b1);
    endtask

    initial begin
        int first, second, al_seen, n, len, kind;

        // Reset with random words: everything reads zero.
        for (int k = 0; k < 3; k++) begin
            tick(10'($urandom_range(0, 1023)), 1'b1);
            chk("reset_outputs", {19'd0, o_bitslip, o_aligned, o_de, o_c1, o_c0, o_data}, 32'd0);
        end

        // Bitslip cadence on pure data.
        first = 0; second = 0; al_seen = 0;
        for (int e = 1; e <= 150; e++) begin
            tick(rnd_data(), 1'b0);
            if (o_bitslip) begin
                if (first == 0) first = e;
                else if (second == 0) second = e;
            end
            if (o_aligned) al_seen = 1;
        end
        chk("bitslip_first", first, 64);
        chk("bitslip_second", second, 144);
        chk("no_align_on_data", al_seen, 0);

        // Lock and decode.
        reset1();
        repeat (15) tick(10'h354, 1'b0);
        chk("lock_not_early", o_aligned, 0);
        tick(10'h354, 1'b0);
        chk("lock_aligned", o_aligned, 1);
        chk("lock_token_out", {o_de, o_c1, o_c0}, 3'b000);
        tick(10'h100, 1'b0);
        chk("dec_100", {o_de, o_data}, {1'b1, 8'h00});
        tick(10'h2FF, 1'b0);
        chk("dec_2ff", {o_de, o_data}, {1'b1, 8'hFE});
        tick(10'h0AB, 1'b0);
        chk("tok_0ab", {o_de, o_c1, o_c0, o_data}, {3'b001, 8'h00});

        // Lock loss after SEARCH_LIMIT data words, then relock.
        reset1();
        repeat (16) tick(10'h354, 1'b0);
        repeat (SL - 1) tick(rnd_data(), 1'b0);
        chk("still_locked", o_aligned, 1);
        tick(rnd_data(), 1'b0);
        chk("lock_lost", {o_aligned, o_de, o_bitslip}, 3'b000);
        repeat (15) tick(10'h2AB, 1'b0);
        chk("relock_not_early", o_aligned, 0);
        tick(10'h2AB, 1'b0);
        chk("relock", {o_aligned, o_c1, o_c0}, 3'b111);

        // Broken run does not lock.
        reset1();
        repeat (15) tick(10'h154, 1'b0);
        tick(10'h100, 1'b0);
        repeat (15) tick(10'h154, 1'b0);
        chk("broken_run", o_aligned, 0);
        tick(10'h154, 1'b0);
        chk("broken_run_lock", {o_aligned, o_c1, o_c0}, 3'b110);

        // Run hit on the last search cycle beats the bitslip.
        reset1();
        repeat (SL - TR) tick(rnd_data(), 1'b0);
        repeat (TR) tick(10'h0AB, 1'b0);
        chk("hit_beats_slip", {o_aligned, o_bitslip}, 2'b10);

        // Reset in the middle of SETTLE.
        reset1();
        repeat (SL) tick(rnd_data(), 1'b0);
        chk("slip_before_settle", o_bitslip, 1);
        repeat (5) tick(rnd_data(), 1'b0);
        tick(10'h354, 1'b1);
        chk("rst_in_settle", {19'd0, o_bitslip, o_aligned, o_de, o_c1, o_c0, o_data}, 32'd0);
        repeat (TR - 1) tick(10'h354, 1'b0);
        chk("settle_abort_no_lock", o_aligned, 0);
        tick(10'h354, 1'b0);
        chk("settle_abort_lock", o_aligned, 1);

        // Random bursts of tokens, data and occasional resets.
        reset1();
        n = 0;
        while (n < 4000) begin
            kind = $urandom_range(0, 19);
            if (kind < 8) begin
                len = $urandom_range(1, 24);
                repeat (len) tick(rnd_tok(), 1'b0);
            end else if (kind < 19) begin
                len = $urandom_range(0, 80);
                repeat (len) tick(rnd_data(), 1'b0);
            end else begin
                len = $urandom_range(1, 2);
                repeat (len) tick(rnd_data(), 1'b1);
            end
            n += len;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
